// File: rtl/fb_pkg.sv
// Shared frame-buffer constants, grant encoding and address-range helper
// used by the frame-buffer arbiter and its write buffer.
package fb_pkg;

   localparam int FB_WIDTH  = 640;
   localparam int FB_HEIGHT = 480;
   localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_VGA  = 2'd1,
      GNT_WR   = 2'd2,
      GNT_RD   = 2'd3
   } gnt_e;

   // Records which non-VGA requester was served most recently.
   typedef enum logic {
      LAST_WR = 1'b0,
      LAST_RD = 1'b1
   } last_e;

   function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] npix);
      return addr < npix;
   endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Registered write-buffer FIFO. DEPTH must be a power of two so the
// pointers wrap naturally; the occupancy counter carries the full/empty state.
module fb_wr_fifo #(
   parameter int WIDTH = 35,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/fb_arbiter.sv
// Single-port frame-buffer arbiter: VGA reads always win, writer and read-back
// share the remaining cycles round-robin. Define FB_ARB_WR_FIFO_EN to buffer writes.
module fb_arbiter #(
   parameter int ADDR_W     = 19,
   parameter int DATA_W     = 16,
   parameter int FB_PIXELS  = fb_pkg::FB_PIXELS,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vga_rd,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic [DATA_W-1:0] vga_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_valid,
   output logic              rd_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_rvalid,
   output logic [DATA_W-1:0] rd_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   import fb_pkg::*;

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
      $error("fb_arbiter: FIFO_DEPTH must be a power of two, at least 2");
   end

   // Handshakes: writer transfers on wr_valid & wr_ready, read-back on
   // rd_valid & rd_ready; requesters hold valid and payload until ready.
   gnt_e              gnt;
   last_e             last_q, last_d;
   logic              wr_pend;
   logic [ADDR_W-1:0] wr_head_addr;
   logic [DATA_W-1:0] wr_head_data;
   logic              vga_in, wr_in, rd_in;
   logic              vga_ok_q, vga_ok_d;
   logic              rd_rvalid_q, rd_rvalid_d;
   logic              rd_ok_q, rd_ok_d;

`ifdef FB_ARB_WR_FIFO_EN
   logic                          init_q;
   logic                          fifo_full, fifo_empty;
   logic [$clog2(FIFO_DEPTH):0]   unused_fifo_count;
   logic [ADDR_W+DATA_W-1:0]      fifo_dout;

   // Holds wr_ready low through reset and releases it one cycle afterwards.
   always_ff @(posedge clk) begin
      if (rst) init_q <= 1'b0;
      else     init_q <= 1'b1;
   end

   assign wr_ready = init_q & ~fifo_full;
   assign wr_pend  = ~fifo_empty;
   assign {wr_head_addr, wr_head_data} = fifo_dout;

   fb_wr_fifo #(
      .WIDTH (ADDR_W + DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_wr_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wr_valid & wr_ready),
      .pop   (gnt == GNT_WR),
      .din   ({wr_addr, wr_data}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (unused_fifo_count)
   );
`else
   assign wr_pend      = wr_valid;
   assign wr_head_addr = wr_addr;
   assign wr_head_data = wr_data;
   assign wr_ready     = (gnt == GNT_WR);
`endif

   assign vga_in = addr_in_range(32'(vga_addr), 32'(FB_PIXELS));
   assign wr_in  = addr_in_range(32'(wr_head_addr), 32'(FB_PIXELS));
   assign rd_in  = addr_in_range(32'(rd_addr), 32'(FB_PIXELS));

   always_comb begin
      gnt = GNT_NONE;
      if (!rst) begin
         if (vga_rd)                   gnt = GNT_VGA;
         else if (wr_pend && rd_valid) gnt = (last_q == LAST_RD) ? GNT_WR : GNT_RD;
         else if (wr_pend)             gnt = GNT_WR;
         else if (rd_valid)            gnt = GNT_RD;
      end
   end

   // Out-of-range accesses are still granted but never reach the BRAM.
   always_comb begin
      last_d      = last_q;
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      vga_ok_d    = 1'b0;
      rd_rvalid_d = 1'b0;
      rd_ok_d     = 1'b0;
      case (gnt)
         GNT_VGA: begin
            mem_en   = vga_in;
            mem_addr = vga_addr;
            vga_ok_d = vga_in;
         end
         GNT_WR: begin
            mem_en    = wr_in;
            mem_we    = wr_in;
            mem_addr  = wr_head_addr;
            mem_wdata = wr_head_data;
            last_d    = LAST_WR;
         end
         GNT_RD: begin
            mem_en      = rd_in;
            mem_addr    = rd_addr;
            rd_rvalid_d = 1'b1;
            rd_ok_d     = rd_in;
            last_d      = LAST_RD;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q      <= LAST_RD;
         vga_ok_q    <= 1'b0;
         rd_rvalid_q <= 1'b0;
         rd_ok_q     <= 1'b0;
      end else begin
         last_q      <= last_d;
         vga_ok_q    <= vga_ok_d;
         rd_rvalid_q <= rd_rvalid_d;
         rd_ok_q     <= rd_ok_d;
      end
   end

   assign rd_ready  = (gnt == GNT_RD);
   assign vga_data  = vga_ok_q ? mem_rdata : '0;
   assign rd_rvalid = rd_rvalid_q;
   assign rd_rdata  = rd_ok_q ? mem_rdata : '0;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural BRAM model; expectations
// cover both the buffered (FB_ARB_WR_FIFO_EN) and direct write builds.
module tb_fb_arbiter;

   localparam int ADDR_W = 19;
   localparam int DATA_W = 16;
`ifdef FB_ARB_WR_FIFO_EN
   localparam bit FIFO_MODE = 1'b1;
`else
   localparam bit FIFO_MODE = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              vga_rd;
   logic [ADDR_W-1:0] vga_addr;
   logic [DATA_W-1:0] vga_data;
   logic              wr_valid, wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              rd_valid, rd_ready;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_rvalid;
   logic [DATA_W-1:0] rd_rdata;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   int n_checks = 0;
   int n_fail   = 0;
   int en_cnt   = 0;
   int we_cnt   = 0;

   always #5 clk = ~clk;

   fb_arbiter #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .FB_PIXELS  (307200),
      .FIFO_DEPTH (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .vga_rd    (vga_rd),
      .vga_addr  (vga_addr),
      .vga_data  (vga_data),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_addr   (rd_addr),
      .rd_rvalid (rd_rvalid),
      .rd_rdata  (rd_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   // Background frame-buffer content for addresses never written.
   function automatic logic [15:0] pat(input int a);
      return 16'(a * 37) ^ 16'hC3A5;
   endfunction

   logic [15:0]   ram [0:8191];
   logic [8191:0] written;

   always @(posedge clk) begin
      if (rst) begin
         written <= '0;
      end else if (mem_en && mem_we) begin
         ram[mem_addr[12:0]]     <= mem_wdata;
         written[mem_addr[12:0]] <= 1'b1;
      end
      if (mem_en && !mem_we)
         mem_rdata <= written[mem_addr[12:0]] ? ram[mem_addr[12:0]] : pat(int'(mem_addr));
   end

   always @(negedge clk) begin
      if (mem_en)           en_cnt <= en_cnt + 1;
      if (mem_en && mem_we) we_cnt <= we_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Every driver step starts 1 time unit after a rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      int  n;
      logic done;
      n = 0;
      done = 1'b0;
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      while (!done && n < 10) begin
         #2;
         if (wr_ready) done = 1'b1;
         tick();
         n++;
      end
      wr_valid = 1'b0;
      check_eq("wr_accept", done, 1);
   endtask

   task automatic rd_req(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d, output logic en);
      int  n;
      logic done;
      n = 0;
      done = 1'b0;
      en = 1'b0;
      rd_valid = 1'b1;
      rd_addr  = a;
      while (!done && n < 10) begin
         #2;
         if (rd_ready) begin
            done = 1'b1;
            en = mem_en;
         end
         tick();
         n++;
      end
      rd_valid = 1'b0;
      check_eq("rd_granted", done, 1);
      #2;
      check_eq("rd_rvalid", rd_rvalid, 1);
      d = rd_rdata;
      tick();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DATA_W-1:0] rb;
      logic              rb_en;
      int                accepts;
      int                snap;

      rst = 1'b1; vga_rd = 1'b0; vga_addr = '0;
      wr_valid = 1'b1; wr_addr = 19'd307210; wr_data = 16'h1111;
      rd_valid = 1'b0; rd_addr = '0;

      // Reset with a writer already waiting.
      repeat (2) @(posedge clk);
      #3;
      check_eq("rst_wr_ready", wr_ready, 0);
      check_eq("rst_rd_ready", rd_ready, 0);
      check_eq("rst_rd_rvalid", rd_rvalid, 0);
      check_eq("rst_rd_rdata", rd_rdata, 0);
      check_eq("rst_vga_data", vga_data, 0);
      check_eq("rst_mem_en", mem_en, 0);
      check_eq("rst_mem_we", mem_we, 0);
      tick();
      rst = 1'b0;
      tick();
      #2;
      check_eq("post_rst_wr_ready", wr_ready, 1);
      check_eq("post_rst_oor_mem_en", mem_en, 0);
      tick();
      wr_valid = 1'b0;
      repeat (4) tick();

      // A full VGA line with both other requesters pending.
      vga_rd = 1'b1; wr_valid = 1'b1; wr_addr = 19'd307201; wr_data = 16'h2222;
      rd_valid = 1'b1; rd_addr = 19'd10;
      accepts = 0;
      for (int i = 0; i < 640; i++) begin
         vga_addr = 19'(2000 + i);
         #2;
         check_eq("vga_mem_cmd", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 19'(2000 + i)});
         check_eq("vga_rd_ready", rd_ready, 0);
         if (i > 0) check_eq("vga_data", vga_data, pat(2000 + i - 1));
         if (wr_valid && wr_ready) accepts++;
         tick();
      end
      vga_rd = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;
      #2;
      check_eq("vga_data_last", vga_data, pat(2639));
      check_eq("vga_wr_accepts", accepts, FIFO_MODE ? 4 : 0);
      tick();
      #2;
      check_eq("vga_data_idle", vga_data, 0);
      repeat (6) tick();

      // Round-robin after reset: WR, RD, WR, RD.
      rst = 1'b1;
      tick();
      rst = 1'b0; vga_rd = 1'b1; vga_addr = 19'd5;
      wr_valid = 1'b1; wr_addr = 19'd6000; wr_data = 16'h1234;
      rd_valid = 1'b1; rd_addr = 19'd6000;
      for (int i = 0; i < 6; i++) begin
         #2;
         check_eq("rr_blocked_rd_ready", rd_ready, 0);
         tick();
      end
      vga_rd = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #2;
         if (i % 2 == 0) begin
            check_eq("rr_wr_cmd", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 19'd6000, 16'h1234});
            check_eq("rr_wr_rd_ready", rd_ready, 0);
         end else begin
            check_eq("rr_rd_cmd", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 19'd6000});
            check_eq("rr_rd_ready", rd_ready, 1);
         end
         if (i == 2) begin
            check_eq("rr_rd_rvalid", rd_rvalid, 1);
            check_eq("rr_rd_rdata", rd_rdata, 16'h1234);
         end
         tick();
      end
      wr_valid = 1'b0; rd_valid = 1'b0;
      repeat (6) tick();

      // Write then read back in range.
      wr_push(19'd1000, 16'h0ABC);
      repeat (2) tick();
      rd_req(19'd1000, rb, rb_en);
      check_eq("rb_en", rb_en, 1);
      check_eq("rb_data", rb, 16'h0ABC);

      // Out-of-range write and read.
      snap = en_cnt;
      wr_push(19'd307200, 16'h7777);
      repeat (3) tick();
      check_eq("oor_wr_mem_en_cycles", en_cnt - snap, 0);
      rd_req(19'd307200, rb, rb_en);
      check_eq("oor_rd_mem_en", rb_en, 0);
      check_eq("oor_rd_data", rb, 0);

      // Out-of-range VGA read right after an in-range one.
      vga_rd = 1'b1; vga_addr = 19'd2000;
      tick();
      vga_addr = 19'd307300;
      #2;
      check_eq("vga_inrange_data", vga_data, pat(2000));
      tick();
      vga_rd = 1'b0;
      #2;
      check_eq("vga_oor_data", vga_data, 0);
      tick();

      // Buffer three writes behind VGA, then reset: none may reach the BRAM.
      vga_rd = 1'b1; vga_addr = 19'd2000; wr_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr_addr = 19'(7000 + i);
         wr_data = 16'(16'hA000 + i);
         tick();
      end
      vga_rd = 1'b0; wr_valid = 1'b0; rst = 1'b1;
      #2;
      check_eq("flush_rst_mem_en", mem_en, 0);
      tick();
      rst = 1'b0;
      snap = we_cnt;
      for (int i = 0; i < 6; i++) begin
         #2;
         if (i == 0) check_eq("flush_wr_ready_rel", wr_ready, 0);
         if (i == 1) check_eq("flush_wr_ready_after", wr_ready, FIFO_MODE ? 1 : 0);
         tick();
      end
      check_eq("flush_no_writes", we_cnt - snap, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
